operand_truncation_encoder: RTL
===============================

Name: operand_truncation_encoder

Overview:
- Front-end encoder that feeds the approximate multiplication unit.
- Converts raw two's-complement operands A (input/pixel) and B (weight) into: sign bits, ACCURATE_DW-bit truncated magnitudes, and shift amounts.
- The downstream accurate core plus barrel shifter rebuild the approximate product from these fields.
- 2-stage pipeline with valid/ready on both sides; one operand pair per cycle; a truncation-event counter for accuracy profiling.

Parameters:
- A_BW, 8, width of signed operand A (input/pixel data)
- B_BW, 8, width of signed operand B (weight)
- ACCURATE_DW, 4, width of the truncated magnitude sent to the accurate multiplier core
- CNT_W, 16, width of the truncation-event counter

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  encoder can accept a pair this cycle
- a_in  input  A_BW  signed operand A (two's complement)
- b_in  input  B_BW  signed operand B (two's complement)
- out_valid  output  1  encoded pair valid
- out_ready  input  1  downstream accepts the encoded pair
- mult_a_out  output  ACCURATE_DW  truncated magnitude of A
- mult_b_out  output  ACCURATE_DW  truncated magnitude of B
- i_sign  output  1  sign of A
- w_sign  output  1  sign of B
- a_shamt  output  $clog2(A_BW)  left-shift amount for A
- b_shamt  output  $clog2(B_BW)  left-shift amount for B
- cnt_clr  input  1  synchronous clear of trunc_count
- trunc_count  output  CNT_W  number of transferred pairs in which either shamt is non-zero

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valids clear; every output register goes to 0 (mult_a_out, mult_b_out, i_sign, w_sign, a_shamt, b_shamt, trunc_count). out_valid = 0.
- Reset asserted mid-operation discards all in-flight pairs. After release, in_ready = 1.
- Stage 1 (S1), registered:
  - sign = operand MSB, forced to 0 when the operand is 0.
  - mag = absolute value as an unsigned A_BW/B_BW-bit value.
  - Most-negative input is exact: -128 gives mag 128.
- Stage 2 (S2), registered outputs: leading-one detect on mag, with p = index of the highest set bit.
  - If mag < 2^ACCURATE_DW: shamt = 0, trunc = mag[ACCURATE_DW-1:0].
  - Else: shamt = p-(ACCURATE_DW-1), trunc = (mag >> shamt)[ACCURATE_DW-1:0]. The result is truncated, not rounded, so trunc MSB = 1.
  - mag = 0: trunc = 0, shamt = 0.
- A and B are encoded independently with identical rules. A maps to i_sign/a_shamt/mult_a_out; B maps to w_sign/b_shamt/mult_b_out.
- Handshake:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load, derived combinationally from register state and out_ready.
  - A transfer occurs when valid && ready.
  - Latency: a pair accepted at edge N is presented with out_valid = 1 after edge N+2 when there is no stall.
  - Throughput: 1 pair/cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, all outputs hold stable and S1 holds. in_ready drops only when both stages are full.
- No bubbles are inserted. No pair is ever dropped or duplicated.
- trunc_count:
  - Increments by 1 on each output transfer where a_shamt != 0 or b_shamt != 0.
  - Saturates at all-ones.
  - cnt_clr has priority over a same-cycle increment: the result is 0.

Test Plan:
- Reset then single pair a_in=100, b_in=-5, out_ready=1 -> two cycles after acceptance: mult_a_out=12, a_shamt=3, i_sign=0, mult_b_out=5, b_shamt=0, w_sign=1, trunc_count=1. The downstream product equals 480, i.e. -480 once w_sign is applied (exact product -500).
- Boundary operands, in sequence:
  - a_in=15 -> (15, shamt 0)
  - a_in=16 -> (8, shamt 1)
  - a_in=-128 -> (8, shamt 4, sign 1)
  - a_in=0 -> (0, 0, sign 0)
  - a_in=-1 -> (1, 0, sign 1)
  - with b_in=127 -> (15, shamt 3).
- Back-to-back stream of 20 random pairs with out_ready=1 -> 20 outputs in order, one per cycle after 2-cycle fill, each matching the reference encoding model; in_ready constantly 1.
- Random out_ready toggling (about 50%) with continuous in_valid -> outputs stable during stalls; in_ready=0 only when both stages are full; order preserved, no loss or duplicate.
- Assert rst_n low for 1 cycle while two pairs are in flight -> out_valid=0 and all outputs 0 immediately (asynchronous); no stale pair emerges after release.
- Counter edge cases:
  - Preload via 65535 truncating transfers, or force CNT_W=4 and use 15 transfers -> counter saturates and holds.
  - cnt_clr coincident with a truncating transfer -> trunc_count=0 next cycle.

Source files
------------

// File: rtl/operand_truncation_encoder.sv
// Two-stage operand encoder for the approximate multiplier: stage 1 splits sign/magnitude,
// stage 2 truncates each magnitude to its leading ACCURATE_DW bits and reports the shift.
module operand_truncation_encoder #(
  parameter int A_BW        = 8,
  parameter int B_BW        = 8,
  parameter int ACCURATE_DW = 4,
  parameter int CNT_W       = 16,
  localparam int A_SHW      = $clog2(A_BW),
  localparam int B_SHW      = $clog2(B_BW)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_BW-1:0]        a_in,
  input  logic [B_BW-1:0]        b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACCURATE_DW-1:0] mult_a_out,
  output logic [ACCURATE_DW-1:0] mult_b_out,
  output logic                   i_sign,
  output logic                   w_sign,
  output logic [A_SHW-1:0]       a_shamt,
  output logic [B_SHW-1:0]       b_shamt,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       trunc_count
);

  // Handshake: a pair moves on an edge where valid && ready are both high.
  // A stage loads when it is empty or the stage after it is loading.
  logic w_s1_load;
  logic w_s2_load;
  logic w_out_xfer;
  logic w_trunc_evt;

  logic                   r_s1_valid;
  logic                   r_s1_a_sign;
  logic                   r_s1_b_sign;
  logic [A_BW-1:0]        r_s1_a_mag;
  logic [B_BW-1:0]        r_s1_b_mag;

  logic                   r_s2_valid;
  logic [ACCURATE_DW-1:0] r_mult_a;
  logic [ACCURATE_DW-1:0] r_mult_b;
  logic                   r_i_sign;
  logic                   r_w_sign;
  logic [A_SHW-1:0]       r_a_shamt;
  logic [B_SHW-1:0]       r_b_shamt;
  logic [CNT_W-1:0]       r_cnt;

  logic [A_SHW-1:0]       w_a_shamt;
  logic [B_SHW-1:0]       w_b_shamt;
  logic [A_BW-1:0]        w_a_shifted;
  logic [B_BW-1:0]        w_b_shifted;

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign in_ready   = w_s1_load;
  assign w_out_xfer = r_s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a_sign <= 1'b0;
      r_s1_b_sign <= 1'b0;
      r_s1_a_mag  <= '0;
      r_s1_b_mag  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        // Unsigned magnitude keeps the most-negative value exact (-128 -> 128).
        r_s1_a_sign <= a_in[A_BW-1] && (a_in != '0);
        r_s1_b_sign <= b_in[B_BW-1] && (b_in != '0);
        r_s1_a_mag  <= a_in[A_BW-1] ? (~a_in + A_BW'(1)) : a_in;
        r_s1_b_mag  <= b_in[B_BW-1] ? (~b_in + B_BW'(1)) : b_in;
      end
    end
  end

  // Leading-one detect: highest set bit at or above ACCURATE_DW sets the shift.
  always_comb begin
    w_a_shamt = '0;
    for (int i = ACCURATE_DW; i < A_BW; i++) begin
      if (r_s1_a_mag[i]) w_a_shamt = A_SHW'(i - (ACCURATE_DW - 1));
    end
    w_a_shifted = r_s1_a_mag >> w_a_shamt;
  end

  always_comb begin
    w_b_shamt = '0;
    for (int i = ACCURATE_DW; i < B_BW; i++) begin
      if (r_s1_b_mag[i]) w_b_shamt = B_SHW'(i - (ACCURATE_DW - 1));
    end
    w_b_shifted = r_s1_b_mag >> w_b_shamt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_mult_a   <= '0;
      r_mult_b   <= '0;
      r_i_sign   <= 1'b0;
      r_w_sign   <= 1'b0;
      r_a_shamt  <= '0;
      r_b_shamt  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_mult_a  <= w_a_shifted[ACCURATE_DW-1:0];
        r_mult_b  <= w_b_shifted[ACCURATE_DW-1:0];
        r_i_sign  <= r_s1_a_sign;
        r_w_sign  <= r_s1_b_sign;
        r_a_shamt <= w_a_shamt;
        r_b_shamt <= w_b_shamt;
      end
    end
  end

  assign w_trunc_evt = w_out_xfer && ((r_a_shamt != '0) || (r_b_shamt != '0));

  // Saturating profile counter; clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_trunc_evt && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_s2_valid;
  assign mult_a_out  = r_mult_a;
  assign mult_b_out  = r_mult_b;
  assign i_sign      = r_i_sign;
  assign w_sign      = r_w_sign;
  assign a_shamt     = r_a_shamt;
  assign b_shamt     = r_b_shamt;
  assign trunc_count = r_cnt;

endmodule
